// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and parameter defaults
// for the LED bank controller.
package led_ctrl_pkg;

    localparam int N_CH_DEF       = 6;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int BLINK_DIV_DEF  = 8;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2
    } mode_t;

    // Encoding 3 is unreachable; treat it as STATIC so the next press recovers.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        logic [1:0] n;
        n = MODE_STATIC;
        case (m)
            MODE_STATIC: n = MODE_BLINK;
            MODE_BLINK:  n = MODE_CHASE;
            MODE_CHASE:  n = MODE_STATIC;
            default:     n = MODE_STATIC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_bank_controller_debounce.sv
// Button conditioner: 2-flop synchroniser, consecutive-edge
// debounce and a one-cycle press pulse on each accepted rise.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Any sample that agrees with the stable level restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (s2 != level) begin
                if (cnt == CMAX) begin
                    level <= s2;
                    cnt   <= '0;
                    press <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_bank_controller.sv
// Switch-driven LED bank with invert and mode buttons:
// static, blinking and chasing display modes.
module led_bank_controller
    import led_ctrl_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] switches,
    input  logic [1:0]      buttons,
    output logic [N_CH-1:0] leds,
    output logic [1:0]      mode
);

    localparam int TW = $clog2(BLINK_DIV);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TW-1:0] TMAX = TW'(BLINK_DIV - 1);
    localparam logic [PW-1:0] PMAX = PW'(N_CH - 1);

    logic [N_CH-1:0] sw_s1;
    logic [N_CH-1:0] sw_s2;
    logic [N_CH-1:0] inv;
    logic [1:0]      mode_q;
    logic [TW-1:0]   tcnt;
    logic            phase;
    logic [PW-1:0]   pos;
    logic            press_inv;
    logic            press_mode;
    logic            tick;
    logic [N_CH-1:0] pattern;
    logic [N_CH-1:0] chase_mask;
    logic [N_CH-1:0] led_next;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_inv (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (buttons[0]),
        .press(press_inv)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_mode (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (buttons[1]),
        .press(press_mode)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;
        end
    end

    always_comb begin
        pattern    = sw_s2 ^ inv;
        tick       = (tcnt == TMAX);
        chase_mask = N_CH'(1) << pos;
        led_next   = pattern;
        case (mode_q)
            MODE_BLINK: led_next = pattern & {N_CH{phase}};
            MODE_CHASE: led_next = pattern & chase_mask;
            default:    led_next = pattern;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv    <= '0;
            mode_q <= MODE_STATIC;
        end else begin
            if (press_inv)
                inv <= inv ^ sw_s2;
            if (press_mode)
                mode_q <= next_mode(mode_q);
        end
    end

    // A mode press restarts the blink/chase timebase from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            phase <= 1'b0;
            pos   <= '0;
        end else if (press_mode) begin
            tcnt  <= '0;
            phase <= 1'b0;
            pos   <= '0;
        end else if (tick) begin
            tcnt  <= '0;
            phase <= ~phase;
            pos   <= (pos == PMAX) ? '0 : pos + 1'b1;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= '0;
            mode <= MODE_STATIC;
        end else begin
            leds <= led_next;
            mode <= (mode_q == 2'd3) ? MODE_STATIC : mode_q;
        end
    end

endmodule

// File: tb/tb_led_bank_controller.sv
// Directed bench for led_bank_controller with an edge-level
// behavioural model compared on every clock.
module tb_led_bank_controller;

    localparam int N   = 6;
    localparam int DEB = 4;
    localparam int DIV = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] switches = '0;
    logic [1:0]   buttons = '0;
    logic [N-1:0] leds;
    logic [1:0]   mode;

    int compared = 0;
    int mismatched = 0;

    led_bank_controller #(
        .N_CH      (N),
        .DEB_CYCLES(DEB),
        .BLINK_DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .switches(switches),
        .buttons (buttons),
        .leds    (leds),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    // Model state: raw input history, debounce windows,
    // pending presses and edges since the last timebase clear.
    logic [N-1:0] m_inv, m_leds, hsw1, hsw2;
    logic [1:0]   m_mode, m_mode_out;
    logic [1:0]   rb1, rb2, m_stable, m_pend;
    logic         win [2][DEB];
    int           e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inv = '0; m_leds = '0; hsw1 = '0; hsw2 = '0;
        m_mode = 2'd0; m_mode_out = 2'd0;
        rb1 = '0; rb2 = '0; m_stable = '0; m_pend = '0;
        e = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEB; i++)
                win[b][i] = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] rsw,
                              input logic [1:0] rbtn);
        logic [N-1:0] pat, nxt;
        logic [1:0]   rose;
        logic         all_diff;
        int           blk;
        pat = hsw2 ^ m_inv;
        blk = e / DIV;
        case (m_mode)
            2'd1:    nxt = (blk % 2 == 1) ? pat : '0;
            2'd2:    nxt = pat & (N'(1) << (blk % N));
            default: nxt = pat;
        endcase
        m_mode_out = m_mode;
        if (m_pend[0])
            m_inv = m_inv ^ hsw2;
        if (m_pend[1]) begin
            m_mode = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
            e = 0;
        end else begin
            e++;
        end
        rose = '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEB - 1; i++)
                win[b][i] = win[b][i+1];
            win[b][DEB-1] = rb2[b];
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++)
                if (win[b][i] == m_stable[b])
                    all_diff = 1'b0;
            if (all_diff) begin
                m_stable[b] = ~m_stable[b];
                rose[b] = m_stable[b];
            end
        end
        m_pend = rose;
        hsw2 = hsw1; hsw1 = rsw;
        rb2 = rb1; rb1 = rbtn;
        m_leds = nxt;
    endtask

    initial begin
        logic [N-1:0] rs;
        logic [1:0]   rb;
        model_reset();
        forever begin
            @(posedge clk);
            rs = switches;
            rb = buttons;
            #1;
            if (!rst_n)
                model_reset();
            else
                model_step(rs, rb);
            check("model_leds", leds, m_leds);
            check("model_mode", mode, m_mode_out);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] bounce [5];
        bounce = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00};

        #12;
        check("reset_leds", leds, 6'b000000);
        check("reset_mode", mode, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        switches = 6'b000101;
        edges(2);
        check("sw_lat2", leds, 6'b000000);
        edges(1);
        check("sw_lat3", leds, 6'b000101);
        check("sw_mode", mode, 2'd0);

        buttons[0] = 1'b1;
        edges(7);
        check("inv_before", leds, 6'b000101);
        edges(1);
        check("inv_press1", leds, 6'b000000);
        edges(2);
        buttons[0] = 1'b0;
        edges(20);
        check("inv_once", leds, 6'b000000);

        buttons[0] = 1'b1;
        edges(8);
        check("inv_press2", leds, 6'b000101);
        edges(2);
        buttons[0] = 1'b0;
        edges(20);

        for (int i = 0; i < 5; i++) begin
            buttons = bounce[i];
            edges(1);
        end
        edges(20);
        check("bounce_leds", leds, 6'b000101);

        switches = 6'b111111;
        edges(3);
        buttons[1] = 1'b1;
        edges(8);
        check("blink_mode", mode, 2'd1);
        check("blink_off", leds, 6'b000000);
        edges(2);
        buttons[1] = 1'b0;
        edges(5);
        check("blink_off_end", leds, 6'b000000);
        edges(1);
        check("blink_on", leds, 6'b111111);
        edges(8);
        check("blink_off2", leds, 6'b000000);

        buttons[1] = 1'b1;
        edges(8);
        check("chase_mode", mode, 2'd2);
        check("chase_p0", leds, 6'b000001);
        edges(2);
        buttons[1] = 1'b0;
        edges(6);
        check("chase_p1", leds, 6'b000010);
        edges(32);
        check("chase_p5", leds, 6'b100000);
        edges(8);
        check("chase_wrap", leds, 6'b000001);

        switches = 6'b000101;
        edges(3);
        buttons = 2'b11;
        edges(8);
        check("both_mode", mode, 2'd0);
        check("both_leds", leds, 6'b000000);
        edges(2);
        buttons = 2'b00;
        edges(20);

        for (int i = 0; i < 2; i++) begin
            buttons[1] = 1'b1;
            edges(10);
            buttons[1] = 1'b0;
            edges(20);
        end
        check("chase_again", mode, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_leds", leds, 6'b000000);
        check("async_rst_mode", mode, 2'd0);
        buttons[0] = 1'b1;
        edges(2);
        @(negedge clk);
        rst_n = 1'b1;
        edges(7);
        check("rst_hold_before", leds, 6'b000101);
        edges(1);
        check("rst_hold_press", leds, 6'b000000);
        edges(20);
        buttons[0] = 1'b0;
        edges(20);
        check("rst_hold_once", leds, 6'b000000);
        check("rst_hold_mode", mode, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/led_bank_controller.md
LED_BANK_CONTROLLER -- requirements
Module: led_bank_controller

Interface
REQ-001 Parameter N_CH, default 6, number of switch/LED channels; legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 4, consecutive stable cycles needed to accept a button level; legal value >= 1.
REQ-003 Parameter BLINK_DIV, default 8, clock cycles per blink/chase tick; legal value >= 2.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 switches  in  N_CH  per-channel enable levels, asynchronous to clk.
REQ-007 buttons  in  2  raw bouncing push-buttons; [0] = invert, [1] = mode; asynchronous to clk.
REQ-008 leds  out  N_CH  registered LED drive.
REQ-009 mode  out  2  registered current display mode.

Function
REQ-010 switches and buttons each pass through a 2-flop synchroniser before any use.
REQ-011 Debounce, per button: the stable level changes only when the synchronised input has differed from it on DEB_CYCLES consecutive edges; any reversal clears the count.
REQ-012 A press event is a single-cycle pulse, asserted in the cycle after the stable level goes 0->1; release generates no event.
REQ-013 pattern = sync_switches XOR inv, where inv is an N_CH-bit register.
REQ-014 Invert press: inv <= inv XOR sync_switches, using the switch value sampled in the same cycle.
REQ-015 Mode FSM: STATIC -> BLINK -> CHASE -> STATIC, advancing one state per mode press.
REQ-016 Unreachable encoding 3 displays as STATIC; the next mode press goes to STATIC.
REQ-017 Tick counter counts 0..BLINK_DIV-1 and wraps to 0; tick is asserted on the cycle where the count equals BLINK_DIV-1.
REQ-018 On tick, phase toggles, and pos advances by 1, wrapping from N_CH-1 to 0.
REQ-019 leds next value by mode:
- STATIC: pattern.
- BLINK: pattern AND replicated phase.
- CHASE: pattern AND onehot(pos).
REQ-020 On a mode press, the tick counter, phase and pos clear to 0 on the same edge as the mode change.
REQ-021 Simultaneous invert and mode presses both take effect on the same edge.
REQ-022 Latency: a clean press whose synchronised level first reads 1 at edge k updates inv/mode at edge k+DEB_CYCLES+1; leds and mode outputs reflect this one edge later.
REQ-023 Latency: a switch change affects leds 3 edges after capture (2 synchroniser edges + output register).
REQ-024 Input glitches shorter than DEB_CYCLES cycles produce no event.

Reset
REQ-025 While rst_n = 0, all flops clear immediately, independent of clk: leds = 0, mode = STATIC, inv = 0, synchronisers = 0, stable levels = 0, debounce counts = 0, tick counter = 0, phase = 0, pos = 0.
REQ-026 Reset asserted mid-debounce or mid-blink discards all partial state; a button held through reset deassertion yields exactly one press after full debounce.

Structure
REQ-027 Package led_ctrl_pkg holds the mode encodings (STATIC = 0, BLINK = 1, CHASE = 2) and the parameter defaults.
REQ-028 Sub-module btn_debounce (synchroniser, counter, stable level, press pulse) is parametrised by DEB_CYCLES and instantiated once per button.

Verification
REQ-029 Reset, then switches = 6'b000101, default parameters -> leds = 6'b000101 three edges later; mode = 0.
REQ-030 btn[0] held 10 cycles with switches = 6'b000101 -> exactly one inv toggle; leds = 6'b000000 at the REQ-022 latency; a second press -> leds = 6'b000101.
REQ-031 btn[0] bounce pattern 1,0,1,1,0 (each 1 cycle) -> no change to leds or inv.
REQ-032 One mode press, switches = 6'b111111 -> mode = 1; leds alternate 6'b000000 / 6'b111111 every 8 cycles.
REQ-033 Second mode press -> mode = 2; leds walk 6'b000001 -> 6'b000010 ... 6'b100000 -> 6'b000001, one step per 8 cycles.
REQ-034 rst_n pulsed low mid-CHASE, between clock edges -> leds = 0 and mode = 0 before the next edge.
